// File: rtl/simon_engine_if.sv
// -----------------------------------------------------------------------------
// simon_engine_if
// Groups the player-facing and display-facing signals of simon_engine.
//   master : the game controller / test driver (drives start and key presses,
//            observes lamp, level and result flags)
//   slave  : simon_engine itself
// Signals:
//   start        level-sampled request to begin a new game
//   player_valid one-cycle key press strobe
//   player_key   pressed key index, qualified by player_valid
//   simon_turn   engine is appending or replaying the sequence
//   simon_key    key being replayed (0 while the lamp is dark)
//   simon_lamp   a replayed step is lit
//   level        current sequence length
//   step_ok      one-cycle pulse after each correct press
//   game_over    game ended (lost or won)
//   game_won     game ended by completing the full sequence
// -----------------------------------------------------------------------------
interface simon_engine_if #(
   parameter int NUM_KEYS = 4,
   parameter int MAX_LEN  = 16
);
   localparam int KEY_W = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic             start;
   logic             player_valid;
   logic [KEY_W-1:0] player_key;
   logic             simon_turn;
   logic [KEY_W-1:0] simon_key;
   logic             simon_lamp;
   logic [LEN_W-1:0] level;
   logic             step_ok;
   logic             game_over;
   logic             game_won;

   modport master (
      output start, player_valid, player_key,
      input  simon_turn, simon_key, simon_lamp, level, step_ok, game_over, game_won
   );

   modport slave (
      input  start, player_valid, player_key,
      output simon_turn, simon_key, simon_lamp, level, step_ok, game_over, game_won
   );
endinterface

// File: rtl/simon_engine.sv
// -----------------------------------------------------------------------------
// simon_engine
// Memory-sequence game engine. Each round appends one pseudo-random key to a
// stored sequence, replays the whole sequence on the lamp with OFF_TICKS dark
// cycles before and ON_TICKS lit cycles per step, then checks the player's
// echo with a per-press timeout. Completing MAX_LEN steps wins the game; a
// wrong key or a timeout loses it.
// Ports:
//   clk      game tick clock, all logic on its rising edge
//   reset_n  asynchronous active-low reset
//   game_if  simon_engine_if.slave (start / press inputs, lamp / status outputs)
// -----------------------------------------------------------------------------
module simon_engine #(
   parameter int          NUM_KEYS      = 4,
   parameter int          MAX_LEN       = 16,
   parameter int          ON_TICKS      = 30,
   parameter int          OFF_TICKS     = 30,
   parameter int          TIMEOUT_TICKS = 120,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input logic           clk,
   input logic           reset_n,
   simon_engine_if.slave game_if
);

   localparam int KEY_W = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam int MAX_OT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int MAX_T  = (MAX_OT > TIMEOUT_TICKS) ? MAX_OT : TIMEOUT_TICKS;
   localparam int TMR_W  = $clog2(MAX_T + 1);

   // An all-zero Galois LFSR never leaves zero, so a zero seed is bumped to 1.
   localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_APPEND = 3'd1;
   localparam logic [2:0] S_GAP    = 3'd2;
   localparam logic [2:0] S_ON     = 3'd3;
   localparam logic [2:0] S_PLAY   = 3'd4;
   localparam logic [2:0] S_LOST   = 3'd5;
   localparam logic [2:0] S_WON    = 3'd6;

   logic [2:0]       r_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_idx;
   logic [TMR_W-1:0] r_timer;
   logic             r_step_ok;
   logic [15:0]      r_lfsr;
   logic [KEY_W-1:0] r_mem [0:MAX_LEN-1];

   logic [15:0]      w_lfsr_next;
   logic [KEY_W-1:0] w_rnd_raw;
   logic [KEY_W-1:0] w_rnd;
   logic [IDX_W-1:0] w_wr_addr;
   logic [IDX_W-1:0] w_rd_addr;
   logic [KEY_W-1:0] w_cur_key;
   logic             w_last_step;
   logic             w_full;
   logic             w_key_match;
   logic             w_gap_done;
   logic             w_on_done;
   logic             w_timeout;

   // ---------------------------------------------------------------------------
   // Random key source
   // ---------------------------------------------------------------------------
   assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);

   // Folding the low bits back into range keeps every stored key < NUM_KEYS;
   // one subtraction suffices because 2**KEY_W < 2*NUM_KEYS.
   always_comb begin
      // NOTE: assign every always_comb output a default before any branch so
      // no path leaves it unassigned; otherwise synthesis infers a latch.
      w_rnd_raw = r_lfsr[KEY_W-1:0];
      w_rnd     = w_rnd_raw;
      if ({1'b0, w_rnd_raw} >= (KEY_W + 1)'(NUM_KEYS)) begin
         w_rnd = w_rnd_raw - KEY_W'(NUM_KEYS);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: clocked state uses non-blocking (<=) so every register samples
      // pre-edge values regardless of statement order; blocking here races.
      if (!reset_n) begin
         r_lfsr <= SEED_EFF;
      end else begin
         r_lfsr <= w_lfsr_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Sequence store
   // ---------------------------------------------------------------------------
   assign w_wr_addr = r_len[IDX_W-1:0];
   assign w_rd_addr = r_idx[IDX_W-1:0];
   assign w_cur_key = r_mem[w_rd_addr];

   // NOTE: the key store is deliberately not reset: every entry is written in
   // APPEND before it is ever read, so a reset would only cost flops/routing.
   always_ff @(posedge clk) begin
      if (r_state == S_APPEND) begin
         r_mem[w_wr_addr] <= w_rnd;
      end
   end

   // ---------------------------------------------------------------------------
   // Game FSM
   // ---------------------------------------------------------------------------
   assign w_last_step = ((r_idx + LEN_W'(1)) == r_len);
   assign w_full      = (r_len == LEN_W'(MAX_LEN));
   // Keys >= NUM_KEYS can never be stored, so they always mismatch here.
   assign w_key_match = (game_if.player_key == w_cur_key);
   assign w_gap_done  = (r_timer == TMR_W'(OFF_TICKS - 1));
   assign w_on_done   = (r_timer == TMR_W'(ON_TICKS - 1));
   assign w_timeout   = (r_timer == TMR_W'(TIMEOUT_TICKS - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_len     <= '0;
         r_idx     <= '0;
         r_timer   <= '0;
         r_step_ok <= 1'b0;
      end else begin
         r_step_ok <= 1'b0;
         case (r_state)
            S_IDLE, S_LOST, S_WON: begin
               if (game_if.start) begin
                  r_len   <= '0;
                  r_idx   <= '0;
                  r_timer <= '0;
                  r_state <= S_APPEND;
               end
            end

            S_APPEND: begin
               r_len   <= r_len + LEN_W'(1);
               r_idx   <= '0;
               r_timer <= '0;
               r_state <= S_GAP;
            end

            S_GAP: begin
               if (w_gap_done) begin
                  r_timer <= '0;
                  r_state <= S_ON;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end

            S_ON: begin
               if (w_on_done) begin
                  r_timer <= '0;
                  if (w_last_step) begin
                     r_idx   <= '0;
                     r_state <= S_PLAY;
                  end else begin
                     r_idx   <= r_idx + LEN_W'(1);
                     r_state <= S_GAP;
                  end
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end

            S_PLAY: begin
               // A press is evaluated before the timeout, so a press in the
               // last allowed cycle still counts.
               if (game_if.player_valid) begin
                  if (w_key_match) begin
                     r_step_ok <= 1'b1;
                     r_timer   <= '0;
                     if (w_last_step) begin
                        r_state <= w_full ? S_WON : S_APPEND;
                     end else begin
                        r_idx <= r_idx + LEN_W'(1);
                     end
                  end else begin
                     r_state <= S_LOST;
                  end
               end else if (w_timeout) begin
                  r_state <= S_LOST;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs (decoded from state so reset clears them without a clock)
   // ---------------------------------------------------------------------------
   assign game_if.simon_turn = (r_state == S_APPEND) || (r_state == S_GAP) || (r_state == S_ON);
   assign game_if.simon_lamp = (r_state == S_ON);
   assign game_if.simon_key  = (r_state == S_ON) ? w_cur_key : '0;
   assign game_if.level      = r_len;
   assign game_if.step_ok    = r_step_ok;
   assign game_if.game_over  = (r_state == S_LOST) || (r_state == S_WON);
   assign game_if.game_won   = (r_state == S_WON);

endmodule

// File: tb/tb_simon_engine.sv
// -----------------------------------------------------------------------------
// tb_simon_engine
// Self-checking bench for simon_engine with NUM_KEYS=3, MAX_LEN=3, ON_TICKS=2,
// OFF_TICKS=2, TIMEOUT_TICKS=8. The reference model tracks the free-running
// LFSR from its polynomial and derives each appended key as (lfsr mod 4) mod 3;
// the expected sequence, replay timing and game results follow from that.
// -----------------------------------------------------------------------------
module tb_simon_engine;

   localparam int NUM_KEYS = 3;
   localparam int MAX_LEN  = 3;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_step_ok_seen = 0;

   int          m_seq[$];
   logic [15:0] m_lfsr;

   simon_engine_if #(.NUM_KEYS(NUM_KEYS), .MAX_LEN(MAX_LEN)) bus ();

   simon_engine #(
      .NUM_KEYS     (NUM_KEYS),
      .MAX_LEN      (MAX_LEN),
      .ON_TICKS     (2),
      .OFF_TICKS    (2),
      .TIMEOUT_TICKS(8),
      .LFSR_SEED    (16'hACE1)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .game_if(bus.slave)
   );

   always #5 clk = ~clk;

   // Polynomial x^16+x^14+x^13+x^11+1, shifting right.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m_lfsr <= 16'hACE1;
      else          m_lfsr <= lfsr_step(m_lfsr);
   end

   always @(negedge clk) begin
      if (bus.step_ok === 1'b1) n_step_ok_seen++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called during an APPEND cycle: the key being stored comes from the LFSR now.
   task automatic model_append();
      m_seq.push_back(int'((m_lfsr % 16'd4) % 16'd3));
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      m_seq.delete();
      model_append();
      n_checks++;
      if (bus.simon_turn !== 1'b1 || bus.level !== 2'd0 || bus.game_over !== 1'b0 || bus.simon_lamp !== 1'b0) begin
         n_fail++;
         $display("FAIL start_append: got turn=%b level=%0d over=%b lamp=%b expected turn=1 level=0 over=0 lamp=0",
                  bus.simon_turn, bus.level, bus.game_over, bus.simon_lamp);
      end
   endtask

   // Entered in an APPEND cycle; leaves the bench in the first PLAY cycle.
   task automatic replay(input int n, input bit noise);
      for (int s = 0; s < n; s++) begin
         for (int c = 0; c < 4; c++) begin
            if (noise) begin
               bus.player_valid = 1'($urandom_range(0, 1));
               bus.player_key   = 2'($urandom_range(0, 3));
            end
            tick();
            n_checks++;
            if (c < 2) begin
               if (bus.simon_lamp !== 1'b0 || bus.simon_turn !== 1'b1 || bus.simon_key !== 2'd0 || bus.level !== 2'(n)) begin
                  n_fail++;
                  $display("FAIL replay_gap r%0d s%0d: got lamp=%b turn=%b key=%0d level=%0d expected lamp=0 turn=1 key=0 level=%0d",
                           n, s, bus.simon_lamp, bus.simon_turn, bus.simon_key, bus.level, n);
               end
            end else begin
               if (bus.simon_lamp !== 1'b1 || bus.simon_turn !== 1'b1 || bus.simon_key !== 2'(m_seq[s]) || bus.level !== 2'(n)) begin
                  n_fail++;
                  $display("FAIL replay_on r%0d s%0d: got lamp=%b turn=%b key=%0d level=%0d expected lamp=1 turn=1 key=%0d level=%0d",
                           n, s, bus.simon_lamp, bus.simon_turn, bus.simon_key, bus.level, m_seq[s], n);
               end
               n_checks++;
               if (bus.simon_key === 2'd3) begin
                  n_fail++;
                  $display("FAIL key_range: got simon_key=3 expected a key below 3");
               end
            end
         end
      end
      bus.player_valid = 1'b0;
      tick();
      n_checks++;
      if (bus.simon_turn !== 1'b0 || bus.simon_lamp !== 1'b0 || bus.game_over !== 1'b0 || bus.step_ok !== 1'b0) begin
         n_fail++;
         $display("FAIL play_entry r%0d: got turn=%b lamp=%b over=%b step_ok=%b expected all 0",
                  n, bus.simon_turn, bus.simon_lamp, bus.game_over, bus.step_ok);
      end
   endtask

   task automatic press(input int key, input bit exp_ok, input bit exp_over, input string name);
      bus.player_valid = 1'b1;
      bus.player_key   = 2'(key);
      tick();
      bus.player_valid = 1'b0;
      n_checks++;
      if (bus.step_ok !== exp_ok || bus.game_over !== exp_over) begin
         n_fail++;
         $display("FAIL %s: got step_ok=%b game_over=%b expected step_ok=%b game_over=%b",
                  name, bus.step_ok, bus.game_over, exp_ok, exp_over);
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      bus.start = 1'b0;
      bus.player_valid = 1'b0;
      bus.player_key = '0;
      #3 reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if ({bus.simon_turn, bus.simon_key, bus.simon_lamp, bus.level, bus.step_ok, bus.game_over, bus.game_won} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got turn=%b key=%0d lamp=%b level=%0d ok=%b over=%b won=%b expected all 0",
                     bus.simon_turn, bus.simon_key, bus.simon_lamp, bus.level, bus.step_ok, bus.game_over, bus.game_won);
         end
         @(posedge clk);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Start at edge 0: APPEND in cycle 1, level 1 in cycle 2, lamp in 4-5, PLAY in 6.
   task automatic test_first_round();
      do_start();
      replay(1, 1'b0);
      press(3, 1'b0, 1'b1, "out_of_range_key");
      n_checks++;
      if (bus.game_won !== 1'b0 || bus.level !== 2'd1) begin
         n_fail++;
         $display("FAIL out_of_range_state: got won=%b level=%0d expected won=0 level=1", bus.game_won, bus.level);
      end
   endtask

   task automatic test_win();
      int ok_base;
      ok_base = n_step_ok_seen;
      do_start();
      for (int r = 1; r <= MAX_LEN; r++) begin
         replay(r, r == 2);
         for (int i = 0; i < r; i++) begin
            press(m_seq[i], 1'b1, (i == r - 1) && (r == MAX_LEN), "win_press");
            if (i == r - 1 && r < MAX_LEN) begin
               model_append();
               n_checks++;
               if (bus.simon_turn !== 1'b1 || bus.level !== 2'(r)) begin
                  n_fail++;
                  $display("FAIL next_round_append: got turn=%b level=%0d expected turn=1 level=%0d",
                           bus.simon_turn, bus.level, r);
               end
            end
         end
      end
      n_checks++;
      if (bus.game_won !== 1'b1 || bus.game_over !== 1'b1 || bus.level !== 2'd3) begin
         n_fail++;
         $display("FAIL win_state: got won=%b over=%b level=%0d expected won=1 over=1 level=3",
                  bus.game_won, bus.game_over, bus.level);
      end
      tick();
      tick();
      n_checks++;
      if (n_step_ok_seen - ok_base !== 6) begin
         n_fail++;
         $display("FAIL step_ok_count: got %0d expected 6", n_step_ok_seen - ok_base);
      end
   endtask

   task automatic test_lose();
      int wrong;
      do_start();
      replay(1, 1'b0);
      press(m_seq[0], 1'b1, 1'b0, "lose_r1_press");
      model_append();
      replay(2, 1'b0);
      press(m_seq[0], 1'b1, 1'b0, "lose_r2_first");
      wrong = (m_seq[1] + 1 + int'($urandom_range(0, 1))) % 3;
      press(wrong, 1'b0, 1'b1, "lose_wrong_key");
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (bus.game_won !== 1'b0 || bus.game_over !== 1'b1 || bus.level !== 2'd2) begin
         n_fail++;
         $display("FAIL lost_state: got won=%b over=%b level=%0d expected won=0 over=1 level=2",
                  bus.game_won, bus.game_over, bus.level);
      end
      do_start();
      replay(1, 1'b0);
      press((m_seq[0] + 1) % 3, 1'b0, 1'b1, "restart_then_wrong");
   endtask

   task automatic test_timeout();
      do_start();
      replay(1, 1'b0);
      for (int i = 0; i < 7; i++) tick();
      n_checks++;
      if (bus.game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_early: got game_over=%b in PLAY cycle 8 expected 0", bus.game_over);
      end
      tick();
      n_checks++;
      if (bus.game_over !== 1'b1 || bus.game_won !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_lost: got over=%b won=%b expected over=1 won=0", bus.game_over, bus.game_won);
      end
      do_start();
      replay(1, 1'b0);
      for (int i = 0; i < 7; i++) tick();
      press(m_seq[0], 1'b1, 1'b0, "press_last_cycle");
      model_append();
      n_checks++;
      if (bus.simon_turn !== 1'b1) begin
         n_fail++;
         $display("FAIL last_cycle_append: got turn=%b expected 1", bus.simon_turn);
      end
      replay(2, 1'b0);
      press((m_seq[0] + 2) % 3, 1'b0, 1'b1, "timeout_wrap_wrong");
   endtask

   task automatic test_many_games();
      for (int g = 0; g < 500; g++) begin
         int idle;
         idle = int'($urandom_range(0, 3));
         for (int i = 0; i < idle; i++) tick();
         do_start();
         replay(1, 1'b0);
         if ($urandom_range(0, 1) == 1) press(3, 1'b0, 1'b1, "many_key3");
         else press((m_seq[0] + 1) % 3, 1'b0, 1'b1, "many_wrong");
      end
   endtask

   task automatic test_reset_abort();
      do_start();
      tick();
      tick();
      tick();
      n_checks++;
      if (bus.simon_lamp !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_setup: got lamp=%b expected 1", bus.simon_lamp);
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (bus.simon_lamp !== 1'b0 || bus.simon_turn !== 1'b0 || bus.level !== 2'd0 || bus.simon_key !== 2'd0) begin
         n_fail++;
         $display("FAIL abort_async: got lamp=%b turn=%b level=%0d key=%0d expected all 0",
                  bus.simon_lamp, bus.simon_turn, bus.level, bus.simon_key);
      end
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      do_start();
      replay(1, 1'b0);
      press(m_seq[0], 1'b1, 1'b0, "after_abort_press");
   endtask

   initial begin
      test_reset();
      test_first_round();
      test_win();
      test_lose();
      test_timeout();
      test_many_games();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
